// File: rtl/window_binarize_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | window_binarize_pkg : config map, CTRL layout, default thresholds  |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
package window_binarize_pkg;

   // Default thresholds, ch2 in the MSB field
   localparam logic [23:0] WB_TL_INIT_DEF = {8'd0,  8'd50,  8'd50};
   localparam logic [23:0] WB_TH_INIT_DEF = {8'd93, 8'd160, 8'd160};

   typedef struct packed {
      logic hs;
      logic vs;
      logic de;
   } wb_timing_t;

   function automatic int unsigned wb_addr_w(input int unsigned nch);
      return $clog2(2 * nch + 1);
   endfunction

   function automatic int unsigned wb_tl_addr(input int unsigned c);
      return 2 * c;
   endfunction

   function automatic int unsigned wb_th_addr(input int unsigned c);
      return 2 * c + 1;
   endfunction

   function automatic int unsigned wb_ctrl_addr(input int unsigned nch);
      return 2 * nch;
   endfunction

   // CTRL: bits nch-1..0 enable mask, bit nch invert
   function automatic int unsigned wb_inv_bit(input int unsigned nch);
      return nch;
   endfunction

endpackage
`default_nettype wire

// File: rtl/wb_channel_cmp.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | wb_channel_cmp : inclusive unsigned range test for one channel     |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module wb_channel_cmp #(
   parameter int unsigned CH_W = 8
) (
   input  logic [CH_W-1:0] i_field,
   input  logic [CH_W-1:0] i_tl,
   input  logic [CH_W-1:0] i_th,
   input  logic            i_en,
   output logic            o_match
);

   // A disabled channel never vetoes; TL > TH can never satisfy both bounds
   assign o_match = ~i_en | ((i_field >= i_tl) & (i_field <= i_th));

endmodule
`default_nettype wire

// File: rtl/window_binarize.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | window_binarize : per-channel window threshold to 1-bit video mask |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module window_binarize
   import window_binarize_pkg::*;
#(
   parameter int unsigned         NCH     = 3,
   parameter int unsigned         CH_W    = 8,
   parameter int unsigned         OUT_W   = 16,
   parameter int unsigned         CNT_W   = 24,
   parameter logic [NCH*CH_W-1:0] TL_INIT = WB_TL_INIT_DEF,
   parameter logic [NCH*CH_W-1:0] TH_INIT = WB_TH_INIT_DEF
) (
   input  logic                          pixelclk,
   input  logic                          reset_n,
   input  logic                          cfg_we,
   input  logic [wb_addr_w(NCH)-1:0]     cfg_addr,
   input  logic [CH_W-1:0]               cfg_wdata,
   input  logic [NCH*CH_W-1:0]           i_data,
   input  logic                          i_hsync,
   input  logic                          i_vsync,
   input  logic                          i_de,
   output logic [OUT_W-1:0]              o_binary,
   output logic                          o_hsync,
   output logic                          o_vsync,
   output logic                          o_de,
   output logic [CNT_W-1:0]              o_fg_count,
   output logic                          o_count_valid
);

   localparam int unsigned AW        = wb_addr_w(NCH);
   localparam int unsigned INV_BIT   = wb_inv_bit(NCH);
   localparam logic [NCH:0] CTRL_RST = {1'b0, {NCH{1'b1}}};

   logic [NCH*CH_W-1:0] tl_sh_q,  tl_sh_d,  th_sh_q,  th_sh_d;
   logic [NCH*CH_W-1:0] tl_act_q, tl_act_d, th_act_q, th_act_d;
   logic [NCH:0]        ctrl_sh_q, ctrl_sh_d, ctrl_act_q, ctrl_act_d;
   logic                vs_prev_q;
   logic                frame_start;

   logic [NCH-1:0]      ch_match;
   logic [NCH-1:0]      match1_q;
   logic                inv1_q;
   wb_timing_t          tim1_q, tim1_d;

   logic [OUT_W-1:0]    binary_q, binary_d;
   wb_timing_t          tim2_q;
   logic [CNT_W-1:0]    cnt_q, cnt_d, fg_count_q, fg_count_d;
   logic                count_valid_q, count_valid_d;
   logic                armed_q, armed_d;
   logic                pix_ones, fg, vs_edge2;

   assign frame_start = i_vsync & ~vs_prev_q;

   always_comb begin
      tl_sh_d   = tl_sh_q;
      th_sh_d   = th_sh_q;
      ctrl_sh_d = ctrl_sh_q;
      if (cfg_we) begin
         for (int c = 0; c < NCH; c++) begin
            if (cfg_addr == AW'(wb_tl_addr(c))) tl_sh_d[c*CH_W +: CH_W] = cfg_wdata;
            if (cfg_addr == AW'(wb_th_addr(c))) th_sh_d[c*CH_W +: CH_W] = cfg_wdata;
         end
         if (cfg_addr == AW'(wb_ctrl_addr(NCH))) ctrl_sh_d = cfg_wdata[NCH:0];
      end
   end

   // Active set samples the pre-write shadow, so a same-cycle write waits a frame
   always_comb begin
      tl_act_d   = frame_start ? tl_sh_q   : tl_act_q;
      th_act_d   = frame_start ? th_sh_q   : th_act_q;
      ctrl_act_d = frame_start ? ctrl_sh_q : ctrl_act_q;
   end

   for (genvar c = 0; c < NCH; c++) begin : g_ch
      wb_channel_cmp #(
         .CH_W(CH_W)
      ) u_cmp (
         .i_field(i_data[c*CH_W +: CH_W]),
         .i_tl   (tl_act_q[c*CH_W +: CH_W]),
         .i_th   (th_act_q[c*CH_W +: CH_W]),
         .i_en   (ctrl_act_q[c]),
         .o_match(ch_match[c])
      );
   end

   assign tim1_d = '{hs: i_hsync, vs: i_vsync, de: i_de};

   // Invert travels with the pixel so a frame-boundary swap stays coherent
   assign pix_ones = ((&match1_q) == inv1_q);
   assign binary_d = pix_ones ? {OUT_W{1'b1}} : {OUT_W{1'b0}};
   assign fg       = tim1_q.de & pix_ones;
   assign vs_edge2 = tim1_q.vs & ~tim2_q.vs;

   always_comb begin
      cnt_d         = cnt_q;
      fg_count_d    = fg_count_q;
      count_valid_d = 1'b0;
      armed_d       = armed_q;
      if (vs_edge2) begin
         cnt_d   = {{(CNT_W-1){1'b0}}, fg};
         armed_d = 1'b1;
         if (armed_q) begin
            fg_count_d    = cnt_q;
            count_valid_d = 1'b1;
         end
      end else if (fg && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge pixelclk or negedge reset_n) begin
      if (!reset_n) begin
         tl_sh_q       <= TL_INIT;
         th_sh_q       <= TH_INIT;
         tl_act_q      <= TL_INIT;
         th_act_q      <= TH_INIT;
         ctrl_sh_q     <= CTRL_RST;
         ctrl_act_q    <= CTRL_RST;
         vs_prev_q     <= 1'b0;
         match1_q      <= '0;
         inv1_q        <= 1'b0;
         tim1_q        <= '0;
         binary_q      <= '0;
         tim2_q        <= '0;
         cnt_q         <= '0;
         fg_count_q    <= '0;
         count_valid_q <= 1'b0;
         armed_q       <= 1'b0;
      end else begin
         tl_sh_q       <= tl_sh_d;
         th_sh_q       <= th_sh_d;
         tl_act_q      <= tl_act_d;
         th_act_q      <= th_act_d;
         ctrl_sh_q     <= ctrl_sh_d;
         ctrl_act_q    <= ctrl_act_d;
         vs_prev_q     <= i_vsync;
         match1_q      <= ch_match;
         inv1_q        <= ctrl_act_q[INV_BIT];
         tim1_q        <= tim1_d;
         binary_q      <= binary_d;
         tim2_q        <= tim1_q;
         cnt_q         <= cnt_d;
         fg_count_q    <= fg_count_d;
         count_valid_q <= count_valid_d;
         armed_q       <= armed_d;
      end
   end

   assign o_binary      = binary_q;
   assign o_hsync       = tim2_q.hs;
   assign o_vsync       = tim2_q.vs;
   assign o_de          = tim2_q.de;
   assign o_fg_count    = fg_count_q;
   assign o_count_valid = count_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_window_binarize.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_window_binarize : table vectors plus scoreboarded sequences     |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_window_binarize;

   logic        pixelclk = 1'b0;
   logic        reset_n  = 1'b0;
   logic        cfg_we   = 1'b0;
   logic [2:0]  cfg_addr = '0;
   logic [7:0]  cfg_wdata = '0;
   logic [23:0] i_data   = '0;
   logic        i_hsync  = 1'b0;
   logic        i_vsync  = 1'b0;
   logic        i_de     = 1'b0;

   logic [15:0] o_binary, s_binary;
   logic        o_hsync, o_vsync, o_de, s_hsync, s_vsync, s_de;
   logic [23:0] o_fg_count;
   logic [3:0]  s_fg_count;
   logic        o_count_valid, s_count_valid;

   window_binarize dut (
      .pixelclk(pixelclk), .reset_n(reset_n),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
      .i_data(i_data), .i_hsync(i_hsync), .i_vsync(i_vsync), .i_de(i_de),
      .o_binary(o_binary), .o_hsync(o_hsync), .o_vsync(o_vsync), .o_de(o_de),
      .o_fg_count(o_fg_count), .o_count_valid(o_count_valid)
   );

   window_binarize #(.CNT_W(4)) dut_s (
      .pixelclk(pixelclk), .reset_n(reset_n),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
      .i_data(i_data), .i_hsync(i_hsync), .i_vsync(i_vsync), .i_de(i_de),
      .o_binary(s_binary), .o_hsync(s_hsync), .o_vsync(s_vsync), .o_de(s_de),
      .o_fg_count(s_fg_count), .o_count_valid(s_count_valid)
   );

   always #5 pixelclk = ~pixelclk;

   typedef struct packed {
      logic [15:0] bin;
      logic        hs;
      logic        vs;
      logic        de;
   } exp_t;

   typedef struct {
      logic [23:0] d;
      logic [15:0] exp;
   } vec_t;

   exp_t sb[$];
   vec_t tab[8];

   int total = 0;
   int bad   = 0;

   // Reference model of the configuration and frame counter
   logic [7:0] m_tl_sh[3], m_th_sh[3], m_tl_act[3], m_th_act[3];
   logic [3:0] m_ctrl_sh, m_ctrl_act;
   logic       m_prev_vs, m_ovs, m_armed;
   int unsigned m_cnt_l, m_cnt_s, m_fgc_l, m_fgc_s;

   task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
      end
   endtask

   task automatic model_reset();
      m_tl_sh  = '{8'd50, 8'd50, 8'd0};
      m_th_sh  = '{8'd160, 8'd160, 8'd93};
      m_tl_act = m_tl_sh;
      m_th_act = m_th_sh;
      m_ctrl_sh  = 4'b0111;
      m_ctrl_act = 4'b0111;
      m_prev_vs = 1'b0;
      m_ovs     = 1'b0;
      m_armed   = 1'b0;
      m_cnt_l = 0; m_cnt_s = 0; m_fgc_l = 0; m_fgc_s = 0;
      sb.delete();
   endtask

   task automatic model_write(input logic [2:0] a, input logic [7:0] wd);
      if (a < 3'd6) begin
         if (a[0]) m_th_sh[a >> 1] = wd;
         else      m_tl_sh[a >> 1] = wd;
      end else if (a == 3'd6) begin
         m_ctrl_sh = wd[3:0];
      end
   endtask

   function automatic logic [15:0] model_bin(input logic [23:0] d);
      logic       m;
      logic [7:0] f;
      m = 1'b1;
      for (int c = 0; c < 3; c++) begin
         f = d[c*8 +: 8];
         if (m_ctrl_act[c] && !((f >= m_tl_act[c]) && (f <= m_th_act[c]))) m = 1'b0;
      end
      return (m ^ m_ctrl_act[3]) ? 16'h0000 : 16'hFFFF;
   endfunction

   task automatic check_out(input exp_t e);
      logic edge_v, fg, exp_v;
      cmp("pixel_out", {o_binary, o_hsync, o_vsync, o_de}, {e.bin, e.hs, e.vs, e.de});
      edge_v = e.vs && !m_ovs;
      m_ovs  = e.vs;
      fg     = e.de && (e.bin == 16'hFFFF);
      exp_v  = 1'b0;
      if (edge_v) begin
         if (m_armed) begin
            exp_v   = 1'b1;
            m_fgc_l = m_cnt_l;
            m_fgc_s = m_cnt_s;
         end
         m_armed = 1'b1;
         m_cnt_l = fg;
         m_cnt_s = fg;
      end else if (fg) begin
         if (m_cnt_l < 32'hFF_FFFF) m_cnt_l++;
         if (m_cnt_s < 15) m_cnt_s++;
      end
      cmp("count_valid",   o_count_valid, exp_v);
      cmp("count_valid_s", s_count_valid, exp_v);
      cmp("fg_count",      o_fg_count,    m_fgc_l);
      cmp("fg_count_s",    s_fg_count,    m_fgc_s);
   endtask

   // One pixel clock: retire the sample due now, then drive and predict the next
   task automatic step(input logic [23:0] d, input logic hs, input logic vs, input logic de,
                       input logic we, input logic [2:0] a, input logic [7:0] wd,
                       input logic [16:0] ovr);
      exp_t e;
      @(posedge pixelclk);
      #1;
      if (sb.size() == 2) check_out(sb.pop_front());
      i_data = d; i_hsync = hs; i_vsync = vs; i_de = de;
      cfg_we = we; cfg_addr = a; cfg_wdata = wd;
      e.bin = ovr[16] ? ovr[15:0] : model_bin(d);
      e.hs = hs; e.vs = vs; e.de = de;
      sb.push_back(e);
      if (vs && !m_prev_vs) begin
         m_tl_act   = m_tl_sh;
         m_th_act   = m_th_sh;
         m_ctrl_act = m_ctrl_sh;
      end
      m_prev_vs = vs;
      if (we) model_write(a, wd);
   endtask

   task automatic pix(input logic [23:0] d, input logic [16:0] ovr);
      step(d, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 8'd0, ovr);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(24'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0, 17'd0);
   endtask

   task automatic wr(input logic [2:0] a, input logic [7:0] wd);
      step(24'd0, 1'b0, 1'b0, 1'b0, 1'b1, a, wd, 17'd0);
   endtask

   // Frame start; an optional config write rides on the vsync-rise cycle
   task automatic vpulse(input logic we, input logic [2:0] a, input logic [7:0] wd);
      step(24'd0, 1'b0, 1'b1, 1'b0, we, a, wd, 17'd0);
      step(24'd0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0, 17'd0);
      idle(2);
   endtask

   task automatic check_zero(input string nm);
      cmp({nm, "_pix"},  {o_binary, o_hsync, o_vsync, o_de}, 19'd0);
      cmp({nm, "_cnt"},  {o_fg_count, o_count_valid}, 25'd0);
      cmp({nm, "_cnts"}, {s_fg_count, s_count_valid, s_binary}, 21'd0);
   endtask

   initial begin
      model_reset();
      tab[0] = '{{8'd80,  8'd100, 8'd100}, 16'h0000};
      tab[1] = '{{8'd94,  8'd100, 8'd100}, 16'hFFFF};
      tab[2] = '{{8'd93,  8'd160, 8'd160}, 16'h0000};
      tab[3] = '{{8'd0,   8'd50,  8'd50},  16'h0000};
      tab[4] = '{{8'd0,   8'd49,  8'd50},  16'hFFFF};
      tab[5] = '{{8'd0,   8'd50,  8'd161}, 16'hFFFF};
      tab[6] = '{{8'd255, 8'd255, 8'd255}, 16'hFFFF};
      tab[7] = '{{8'd10,  8'd120, 8'd70},  16'h0000};

      repeat (3) @(posedge pixelclk);
      #1;
      check_zero("reset");
      reset_n = 1'b1;

      // Default thresholds; first frame start after reset reports nothing
      idle(2);
      vpulse(1'b0, 3'd0, 8'd0);
      for (int i = 0; i < 8; i++)
         step(tab[i].d, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 8'd0, {1'b1, tab[i].exp});
      idle(2);

      // Mid-frame TH write on ch2 holds off until the next frame
      step({8'd150, 8'd100, 8'd100}, 1'b0, 1'b0, 1'b1, 1'b1, 3'd5, 8'd200, {1'b1, 16'hFFFF});
      for (int i = 0; i < 4; i++) pix({8'd150, 8'd100, 8'd100}, {1'b1, 16'hFFFF});
      vpulse(1'b0, 3'd0, 8'd0);
      for (int i = 0; i < 4; i++) pix({8'd150, 8'd100, 8'd100}, {1'b1, 16'h0000});
      idle(2);

      // Invert with empty mask: a 640-pixel all-foreground frame
      wr(3'd6, 8'h08);
      vpulse(1'b0, 3'd0, 8'd0);
      for (int ln = 0; ln < 4; ln++) begin
         for (int i = 0; i < 160; i++) pix(24'($urandom), {1'b1, 16'hFFFF});
         step(24'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0, 17'd0);
         step(24'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0, 17'd0);
      end
      vpulse(1'b0, 3'd0, 8'd0);
      for (int i = 0; i < 20; i++) pix(24'($urandom), {1'b1, 16'hFFFF});
      idle(3);

      // Restore CTRL; ch0 TL write on the vsync-rise cycle lands a frame later
      wr(3'd6, 8'h07);
      vpulse(1'b1, 3'd0, 8'd170);
      for (int i = 0; i < 3; i++) pix({8'd0, 8'd100, 8'd100}, {1'b1, 16'h0000});
      wr(3'd1, 8'd160);
      wr(3'd7, 8'hFF);
      vpulse(1'b0, 3'd0, 8'd0);
      pix({8'd0, 8'd100, 8'd100}, {1'b1, 16'hFFFF});
      pix({8'd0, 8'd100, 8'd165}, {1'b1, 16'hFFFF});
      pix({8'd0, 8'd100, 8'd170}, {1'b1, 16'hFFFF});
      pix({8'd80, 8'd100, 8'd100}, {1'b1, 16'hFFFF});

      // Asynchronous reset in the middle of a frame
      @(posedge pixelclk);
      #3;
      reset_n = 1'b0;
      #1;
      check_zero("async_reset");
      model_reset();
      i_data = '0; i_hsync = 1'b0; i_vsync = 1'b0; i_de = 1'b0; cfg_we = 1'b0;
      repeat (2) @(posedge pixelclk);
      #1;
      check_zero("reset_hold");
      reset_n = 1'b1;

      for (int i = 0; i < 3; i++) pix({8'd80, 8'd100, 8'd100}, {1'b1, 16'h0000});
      vpulse(1'b0, 3'd0, 8'd0);
      for (int i = 0; i < 5; i++) pix({8'd94, 8'd100, 8'd100}, {1'b1, 16'hFFFF});
      pix({8'd0, 8'd100, 8'd100}, {1'b1, 16'h0000});
      vpulse(1'b0, 3'd0, 8'd0);
      idle(3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/window_binarize.md
WINDOW_BINARIZE -- requirements
Module: window_binarize

Interface
REQ-001 Parameter NCH, default 3: number of input channels.
REQ-002 Parameter CH_W, default 8: bits per channel; NCH+1 <= CH_W SHALL hold.
REQ-003 Parameter OUT_W, default 16: output pixel width.
REQ-004 Parameter CNT_W, default 24: foreground counter width.
REQ-005 Parameter TL_INIT / TH_INIT, default {0,50,50} / {93,160,160} for channels 2..0 (ch2 = MSB field): reset thresholds.
REQ-006 Port pixelclk  in  1: pixel clock; all logic rising-edge.
REQ-007 Port reset_n  in  1: asynchronous, active-low reset.
REQ-008 Port cfg_we  in  1: config write strobe, one write per cycle.
REQ-009 Port cfg_addr  in  clog2(2*NCH+1): addr 2c = TL of channel c, 2c+1 = TH of channel c, 2*NCH = CTRL.
REQ-010 Port cfg_wdata  in  CH_W: write data; CTRL bit NCH = invert, bits NCH-1..0 = channel enable mask.
REQ-011 Port i_data  in  NCH*CH_W: pixel, channel c at bits [c*CH_W +: CH_W].
REQ-012 Port i_hsync, i_vsync, i_de  in  1 each: video timing, vsync active-high.
REQ-013 Port o_binary  out  OUT_W: binarised pixel, all-zeros or all-ones.
REQ-014 Port o_hsync, o_vsync, o_de  out  1 each: timing delayed to match o_binary.
REQ-015 Port o_fg_count  out  CNT_W: foreground pixel count of previous frame.
REQ-016 Port o_count_valid  out  1: one-cycle pulse when o_fg_count updates.

Function
REQ-017 Config writes SHALL land in shadow registers; addresses > 2*NCH SHALL be ignored.
REQ-018 Frame start SHALL be i_vsync=1 with registered previous i_vsync=0.
REQ-019 On frame start, all shadow values SHALL copy to active registers; a write in the same cycle updates shadow only, effective from the following frame.
REQ-020 Channel c matches when TL_c <= field_c <= TH_c (unsigned, inclusive); TL_c > TH_c never matches; disabled channel counts as matched.
REQ-021 Pixel match = AND of all channel matches; mask all-zero => every pixel matches.
REQ-022 o_binary SHALL be all-zeros on match, all-ones otherwise; invert=1 swaps these.
REQ-023 Pipeline latency SHALL be exactly 2 cycles for o_binary, o_hsync, o_vsync, o_de (stage 1 compare, stage 2 combine/invert).
REQ-024 Foreground = stage-2 pixel with de=1 and all-ones value; counter increments by 1 per foreground pixel, saturating at 2^CNT_W-1.
REQ-025 On frame start at stage 2 (delayed o_vsync rising edge), o_fg_count SHALL load counter, o_count_valid pulses 1 cycle, counter restarts at 0 plus that cycle's foreground pixel if any.
REQ-026 Active thresholds SHALL never change mid-frame.

Reset
REQ-027 reset_n low SHALL asynchronously clear o_binary, o_hsync, o_vsync, o_de, o_fg_count, o_count_valid, counter, pipeline and vsync-edge registers to 0.
REQ-028 Shadow and active thresholds SHALL reset to TL_INIT/TH_INIT; CTRL SHALL reset to invert=0, mask all-ones.
REQ-029 Reset mid-frame SHALL discard the partial count; first o_count_valid follows the second frame start after release.

Structure
REQ-030 Shared package SHALL hold config address constants, CTRL bit positions and default threshold constants.
REQ-031 One sub-module, wb_channel_cmp (one channel's range compare with enable), SHALL be instantiated NCH times.

Verification
REQ-032 Defaults, pixel {80,100,100} de=1 -> o_binary=16'h0000 two cycles later; {94,100,100} -> 16'hFFFF.
REQ-033 Write ch2 TH=200 mid-frame, pixel {150,100,100} -> FFFF until next frame start, 0000 after.
REQ-034 CTRL invert=1 mask=3'b000 -> every pixel 16'hFFFF; frame of 640 de pixels -> next frame start gives o_fg_count=640, o_count_valid one cycle.
REQ-035 CNT_W=4, 20 foreground pixels -> o_fg_count=15.
REQ-036 Write ch0 TL=170 TH=160 -> all pixels FFFF from next frame; write to addr 7 -> no state change.
REQ-037 Assert reset_n mid-frame -> all outputs 0 immediately, thresholds return to defaults, no o_count_valid at first frame start after release.
